// File: rtl/acc_req_arbiter_pkg.sv
// Shared types and helpers for the accelerator request arbiter.
// Arbiter FSM encoding plus the requester-ID type used by the in-order response FIFO.
package acc_req_arbiter_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, LOCK = 1'b1} arb_state_e;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_LOCK = 1'b1;

  localparam int unsigned NumReqDflt = 2;
  typedef logic [$clog2(NumReqDflt)-1:0] acc_req_id_t;

  // (base + off) mod n, valid for base < n and off < n
  function automatic int unsigned wrap_add(input int unsigned base, input int unsigned off,
                                           input int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/acc_arb_id_fifo.sv
// In-order requester-ID FIFO: head is the owner of the oldest unanswered instruction.
// No bypass; a push into a full FIFO is taken only alongside a pop in the same cycle.
module acc_arb_id_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);
  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Depth-1:0][Width-1:0]   mem_q, mem_d;
  logic                          do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[PtrW-1:0]];

  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[PtrW-1:0]] = data_i;
      wr_ptr_d = wr_ptr_q + (PtrW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/acc_req_arbiter.sv
// Round-robin arbiter sharing one accelerator channel; grant locked until handshake, 1 cycle
// arbitration latency, responses routed in order via an ID FIFO. Perf counters: ACC_REQ_ARBITER_PERF_EN.
module acc_req_arbiter
  import acc_req_arbiter_pkg::*;
#(
  parameter int unsigned NumReq     = 2,
  parameter int unsigned XLEN       = 64,
  parameter int unsigned OutstDepth = 4,
  parameter int unsigned CntWidth   = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumReq-1:0]          req_valid_i,
  output logic [NumReq-1:0]          req_ready_o,
  input  logic [NumReq*32-1:0]       req_insn_i,
  input  logic [NumReq*XLEN-1:0]     req_rs1_i,
  input  logic [NumReq*XLEN-1:0]     req_rs2_i,
  output logic [NumReq-1:0]          resp_valid_o,
  input  logic [NumReq-1:0]          resp_ready_i,
  output logic [XLEN-1:0]            resp_result_o,
  output logic                       resp_error_o,
  output logic                       acc_req_valid_o,
  input  logic                       acc_req_ready_i,
  output logic [31:0]                acc_insn_o,
  output logic [XLEN-1:0]            acc_rs1_o,
  output logic [XLEN-1:0]            acc_rs2_o,
  input  logic                       acc_resp_valid_i,
  output logic                       acc_resp_ready_o,
  input  logic [XLEN-1:0]            acc_resp_result_i,
  input  logic                       acc_resp_error_i,
  output logic                       busy_o,
  output logic                       orphan_o,
  output logic [NumReq*CntWidth-1:0] perf_grant_cnt_o
);
  localparam int unsigned IdW = $clog2(NumReq);

  logic [0:0]     state_q, state_d;
  logic [IdW-1:0] win_q, win_d, rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0] arb_idx, cand, head;
  logic           arb_found, fifo_full, fifo_empty, push, pop, handshake;
  logic           orphan_q, orphan_d;

  // First valid requester at or after rr_ptr, wrapping
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = IdW'(wrap_add(32'(rr_ptr_q), i, NumReq));
      if (!arb_found && req_valid_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign handshake = (state_q == ARB_LOCK) && req_valid_i[win_q] && acc_req_ready_i;

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    rr_ptr_d = rr_ptr_q;
    push     = 1'b0;
    if (state_q == ARB_IDLE) begin
      if (arb_found && !fifo_full) begin
        state_d = ARB_LOCK;
        win_d   = arb_idx;
      end
    end else if (handshake) begin
      push     = 1'b1;
      rr_ptr_d = IdW'(wrap_add(32'(win_q), 1, NumReq));
      state_d  = ARB_IDLE;
    end
  end

  always_comb begin
    req_ready_o     = '0;
    acc_req_valid_o = 1'b0;
    acc_insn_o      = '0;
    acc_rs1_o       = '0;
    acc_rs2_o       = '0;
    if (state_q == ARB_LOCK) begin
      acc_req_valid_o    = req_valid_i[win_q];
      req_ready_o[win_q] = acc_req_ready_i;
      acc_insn_o         = req_insn_i[32*win_q +: 32];
      acc_rs1_o          = req_rs1_i[XLEN*win_q +: XLEN];
      acc_rs2_o          = req_rs2_i[XLEN*win_q +: XLEN];
    end
  end

  // With nothing outstanding, responses are swallowed and flagged as orphans
  always_comb begin
    resp_valid_o     = '0;
    acc_resp_ready_o = !rst_i;
    if (!fifo_empty) begin
      resp_valid_o[head] = acc_resp_valid_i;
      acc_resp_ready_o   = resp_ready_i[head] && !rst_i;
    end
    pop      = !fifo_empty && acc_resp_valid_i && acc_resp_ready_o;
    orphan_d = orphan_q | (fifo_empty & acc_resp_valid_i);
  end

  assign resp_result_o = acc_resp_result_i;
  assign resp_error_o  = acc_resp_error_i;
  assign busy_o        = (state_q == ARB_LOCK) || !fifo_empty;
  assign orphan_o      = orphan_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      win_q    <= '0;
      rr_ptr_q <= '0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      rr_ptr_q <= rr_ptr_d;
      orphan_q <= orphan_d;
    end
  end

  acc_arb_id_fifo #(.Depth(OutstDepth), .Width(IdW)) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (win_q),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

`ifdef ACC_REQ_ARBITER_PERF_EN
  logic [NumReq-1:0][CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (handshake && (cnt_q[win_q] != {CntWidth{1'b1}})) begin
      cnt_d[win_q] = cnt_q[win_q] + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign perf_grant_cnt_o = cnt_q;
`else
  assign perf_grant_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  for (genvar k = 0; k < NumReq; k++) begin : g_hold
    a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (req_valid_i[k] && !req_ready_o[k]) |=>
        (req_valid_i[k] && $stable(req_insn_i[32*k +: 32]) &&
         $stable(req_rs1_i[XLEN*k +: XLEN]) && $stable(req_rs2_i[XLEN*k +: XLEN])));
  end

  a_no_same_cycle_resp: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && fifo_empty && acc_resp_valid_i));
`endif

endmodule

// File: tb/tb_acc_req_arbiter.sv
// Randomized + directed bench for acc_req_arbiter against a queue-based behavioural model.
module tb_acc_req_arbiter;
  localparam int N = 2, XL = 64, D = 4, CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_i;
  logic [N-1:0]    req_valid_i, req_ready_o, resp_valid_o, resp_ready_i;
  logic [N*32-1:0] req_insn_i;
  logic [N*XL-1:0] req_rs1_i, req_rs2_i;
  logic [XL-1:0]   resp_result_o, acc_rs1_o, acc_rs2_o, acc_resp_result_i;
  logic            resp_error_o, acc_req_valid_o, acc_req_ready_i, acc_resp_valid_i;
  logic            acc_resp_ready_o, acc_resp_error_i, busy_o, orphan_o;
  logic [31:0]     acc_insn_o;
  logic [N*CW-1:0] perf_grant_cnt_o;

  acc_req_arbiter #(.NumReq(N), .XLEN(XL), .OutstDepth(D), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_insn_i(req_insn_i),
    .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_result_o(resp_result_o), .resp_error_o(resp_error_o),
    .acc_req_valid_o(acc_req_valid_o), .acc_req_ready_i(acc_req_ready_i),
    .acc_insn_o(acc_insn_o), .acc_rs1_o(acc_rs1_o), .acc_rs2_o(acc_rs2_o),
    .acc_resp_valid_i(acc_resp_valid_i), .acc_resp_ready_o(acc_resp_ready_o),
    .acc_resp_result_i(acc_resp_result_i), .acc_resp_error_i(acc_resp_error_i),
    .busy_o(busy_o), .orphan_o(orphan_o), .perf_grant_cnt_o(perf_grant_cnt_o)
  );

  int n_checks = 0, n_pass = 0;
  int cyc = 0;

  // Requester / accelerator environment
  int          want [N];
  int          seq  [N];
  logic [31:0] b_insn [N];
  logic [XL-1:0] b_rs1 [N], b_rs2 [N];
  int          ara_cnt = 0;
  bit          ara_auto = 0, rnd_mode = 0;
  int          g_owner [$];
  int          g_cyc   [$];

  // Behavioural model
  bit          m_locked = 0;
  int          m_owner = 0, m_rr = 0;
  int          m_idq [$];
  bit          m_orphan = 0;
  int unsigned m_cnt [N];
  int          hs_owner;
  bit          popped;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic new_payload(input int k);
    seq[k]++;
    b_insn[k] = {8'(k), 24'(seq[k])};
    b_rs1[k]  = {$urandom, $urandom};
    b_rs2[k]  = {$urandom, $urandom};
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req_valid_i[k]           = (want[k] > 0);
      req_insn_i[32*k +: 32]   = b_insn[k];
      req_rs1_i[XL*k +: XL]    = b_rs1[k];
      req_rs2_i[XL*k +: XL]    = b_rs2[k];
    end
    if (rnd_mode) begin
      acc_req_ready_i = 1'($urandom_range(0, 1));
      resp_ready_i    = N'($urandom_range(0, 3));
    end
    if (ara_auto) begin
      acc_resp_valid_i  = (ara_cnt > 0) && (!rnd_mode || ($urandom_range(0, 2) != 0));
      acc_resp_result_i = {$urandom, $urandom};
      acc_resp_error_i  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic compare_model();
    logic [N-1:0]    e_rdy, e_rv;
    logic            e_arr;
    logic [N*CW-1:0] e_perf;
    int sz;
    sz = m_idq.size();
    e_rdy = '0;
    e_rv  = '0;
    e_arr = 1'b1;
    if (m_locked) e_rdy[m_owner] = acc_req_ready_i;
    if (sz > 0) begin
      e_rv[m_idq[0]] = acc_resp_valid_i;
      e_arr = resp_ready_i[m_idq[0]];
    end
    e_perf = '0;
`ifdef ACC_REQ_ARBITER_PERF_EN
    for (int k = 0; k < N; k++) e_perf[CW*k +: CW] = CW'(m_cnt[k]);
`endif
    chk("req_ready", req_ready_o, e_rdy);
    chk("acc_req_valid", acc_req_valid_o, m_locked && req_valid_i[m_owner]);
    chk("acc_insn", acc_insn_o, m_locked ? b_insn[m_owner] : 32'h0);
    chk("acc_rs1", acc_rs1_o, m_locked ? b_rs1[m_owner] : '0);
    chk("acc_rs2", acc_rs2_o, m_locked ? b_rs2[m_owner] : '0);
    chk("resp_valid", resp_valid_o, e_rv);
    chk("acc_resp_ready", acc_resp_ready_o, e_arr);
    chk("resp_result", resp_result_o, acc_resp_result_i);
    chk("resp_error", resp_error_o, acc_resp_error_i);
    chk("busy", busy_o, m_locked || (sz > 0));
    chk("orphan", orphan_o, m_orphan);
    chk("perf", perf_grant_cnt_o, e_perf);
  endtask

  task automatic model_step();
    int sz, c;
    sz = m_idq.size();
    hs_owner = -1;
    popped   = 0;
    if (rst_i) begin
      m_locked = 0; m_rr = 0; m_orphan = 0;
      m_idq.delete();
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
      return;
    end
    if (sz > 0 && acc_resp_valid_i && resp_ready_i[m_idq[0]]) popped = 1;
    if (sz == 0 && acc_resp_valid_i) m_orphan = 1;
    if (m_locked) begin
      if (req_valid_i[m_owner] && acc_req_ready_i) hs_owner = m_owner;
    end else if (sz < D) begin
      for (int i = 0; i < N; i++) begin
        c = (m_rr + i) % N;
        if (!m_locked && req_valid_i[c]) begin
          m_locked = 1;
          m_owner  = c;
        end
      end
    end
    if (popped) void'(m_idq.pop_front());
    if (hs_owner >= 0) begin
      m_idq.push_back(hs_owner);
      m_rr = (hs_owner + 1) % N;
      m_locked = 0;
      if (m_cnt[hs_owner] != 32'hFFFF_FFFF) m_cnt[hs_owner]++;
    end
  endtask

  task automatic pre();
    drive();
    #2;
  endtask

  task automatic post();
    if (!rst_i) compare_model();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    if (hs_owner >= 0) begin
      want[hs_owner]--;
      new_payload(hs_owner);
      ara_cnt++;
      g_owner.push_back(hs_owner);
      g_cyc.push_back(cyc);
    end
    if (popped) ara_cnt--;
  endtask

  task automatic cycle();
    pre();
    post();
  endtask

  initial begin
    int base, n1;
    rst_i = 1'b1;
    acc_req_ready_i = 1'b0; resp_ready_i = '0; acc_resp_valid_i = 1'b0;
    acc_resp_result_i = '0; acc_resp_error_i = 1'b0;
    req_valid_i = '0; req_insn_i = '0; req_rs1_i = '0; req_rs2_i = '0;
    for (int k = 0; k < N; k++) begin
      want[k] = 0; seq[k] = 0; m_cnt[k] = 0;
      new_payload(k);
    end
    #1;

    // Reset state
    repeat (3) cycle();
    pre();
    chk("t1_req_ready", req_ready_o, 2'b00);
    chk("t1_acc_req_valid", acc_req_valid_o, 1'b0);
    chk("t1_resp_valid", resp_valid_o, 2'b00);
    chk("t1_acc_resp_ready", acc_resp_ready_o, 1'b0);
    chk("t1_busy", busy_o, 1'b0);
    chk("t1_orphan", orphan_o, 1'b0);
    chk("t1_perf", perf_grant_cnt_o, 64'h0);
    post();
    rst_i = 1'b0;
    pre();
    chk("t1_idle_resp_ready", acc_resp_ready_o, 1'b1);
    post();

    // Both requesters pending, Ara always ready
    acc_req_ready_i = 1'b1; resp_ready_i = 2'b11; ara_auto = 1;
    want[0] = 5; want[1] = 5;
    base = g_owner.size();
    for (int i = 0; i < 80 && (g_owner.size() - base) < 10; i++) cycle();
    chk("t2_grant_total", g_owner.size() - base, 10);
    if (g_owner.size() - base >= 4) begin
      for (int i = 0; i < 4; i++) chk("t2_grant_order", g_owner[base+i], i % 2);
      for (int i = 1; i < 4; i++) chk("t2_grant_gap", g_cyc[base+i] - g_cyc[base+i-1], 2);
    end
    for (int i = 0; i < 20 && (ara_cnt > 0 || m_locked); i++) cycle();
    chk("t2_drained", ara_cnt, 0);
`ifdef ACC_REQ_ARBITER_PERF_EN
    chk("t2_perf0", perf_grant_cnt_o[31:0], 32'd5);
    chk("t2_perf1", perf_grant_cnt_o[63:32], 32'd5);
`else
    chk("t2_perf0", perf_grant_cnt_o[31:0], 32'd0);
    chk("t2_perf1", perf_grant_cnt_o[63:32], 32'd0);
`endif

    // Outstanding limit: 5th instruction stalls until a response pops
    ara_auto = 0; acc_resp_valid_i = 1'b0;
    want[1] = 5;
    base = g_owner.size();
    repeat (14) cycle();
    n1 = 0;
    for (int i = base; i < g_owner.size(); i++) if (g_owner[i] == 1) n1++;
    chk("t3_stall_grants", n1, 4);
    pre();
    chk("t3_busy", busy_o, 1'b1);
    chk("t3_stalled_valid", acc_req_valid_o, 1'b0);
    post();
    acc_resp_valid_i = 1'b1; resp_ready_i = 2'b10; acc_resp_result_i = 64'h55;
    pre();
    chk("t3_pop_route", resp_valid_o, 2'b10);
    chk("t3_pop_ready", acc_resp_ready_o, 1'b1);
    post();
    acc_resp_valid_i = 1'b0;
    repeat (4) cycle();
    chk("t3_fifth_granted", g_owner.size() - base, 5);
    ara_auto = 1; resp_ready_i = 2'b11;
    for (int i = 0; i < 30 && (ara_cnt > 0 || m_locked); i++) cycle();
    chk("t3_drained", ara_cnt, 0);

    // In-order response routing with owner backpressure
    ara_auto = 0; acc_resp_valid_i = 1'b0;
    want[0] = 1;
    for (int i = 0; i < 10 && want[0] > 0; i++) cycle();
    want[1] = 1;
    for (int i = 0; i < 10 && want[1] > 0; i++) cycle();
    chk("t4_both_accepted", want[0] + want[1], 0);
    cycle();
    resp_ready_i = 2'b10; acc_resp_valid_i = 1'b1; acc_resp_result_i = 64'hA;
    pre();
    chk("t4_route_a", resp_valid_o, 2'b01);
    chk("t4_hold_a", acc_resp_ready_o, 1'b0);
    chk("t4_result_a", resp_result_o, 64'hA);
    post();
    pre();
    chk("t4_hold_a2", acc_resp_ready_o, 1'b0);
    post();
    resp_ready_i = 2'b11;
    pre();
    chk("t4_route_a3", resp_valid_o, 2'b01);
    chk("t4_accept_a", acc_resp_ready_o, 1'b1);
    post();
    acc_resp_result_i = 64'hB;
    pre();
    chk("t4_route_b", resp_valid_o, 2'b10);
    chk("t4_result_b", resp_result_o, 64'hB);
    post();
    acc_resp_valid_i = 1'b0;
    pre();
    chk("t4_empty", busy_o, 1'b0);
    post();

    // Orphan response
    acc_resp_valid_i = 1'b1;
    cycle();
    acc_resp_valid_i = 1'b0;
    pre();
    chk("t5_orphan_set", orphan_o, 1'b1);
    post();
    repeat (5) cycle();
    pre();
    chk("t5_orphan_sticky", orphan_o, 1'b1);
    post();

    // Reset while locked with 2 IDs outstanding
    want[0] = 3; want[1] = 3; acc_req_ready_i = 1'b1;
    for (int i = 0; i < 20 && !(m_idq.size() == 2 && m_locked); i++) cycle();
    chk("t6_setup", (m_idq.size() == 2) && m_locked, 1'b1);
    pre();
    chk("t6_busy_before", busy_o, 1'b1);
    post();
    rst_i = 1'b1; want[0] = 0; want[1] = 0; ara_cnt = 0;
    cycle();
    rst_i = 1'b0;
    pre();
    chk("t6_busy", busy_o, 1'b0);
    chk("t6_acc_req_valid", acc_req_valid_o, 1'b0);
    chk("t6_orphan_cleared", orphan_o, 1'b0);
    chk("t6_resp_ready", acc_resp_ready_o, 1'b1);
    post();

    // Randomized traffic
    rnd_mode = 1; ara_auto = 1;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++)
        if (want[k] == 0 && $urandom_range(0, 3) == 0) want[k] = $urandom_range(1, 4);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
